// File: rtl/legv8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : legv8_pkg
// Brief    : Opcodes, state codes and mux encodings for the multicycle control
// Revision : 1.0
// ============================================================================
package legv8_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_RWB      = 4'd7,
        S_CBZ      = 4'd8,
        S_B        = 4'd9,
        S_BL       = 4'd10,
        S_BR       = 4'd11,
        S_HALT     = 4'd15
    } state_e;

    localparam logic [10:0] OP_LDUR   = 11'h7C2;
    localparam logic [10:0] OP_STUR   = 11'h7C0;
    localparam logic [10:0] OP_ADD    = 11'h458;
    localparam logic [10:0] OP_SUB    = 11'h658;
    localparam logic [10:0] OP_AND    = 11'h450;
    localparam logic [10:0] OP_ORR    = 11'h550;
    localparam logic [10:0] OP_BR     = 11'h6B0;
    localparam logic [7:0]  OP_CBZ_HI = 8'hB4;
    localparam logic [5:0]  OP_B_HI   = 6'h05;
    localparam logic [5:0]  OP_BL_HI  = 6'h25;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_DIMM  = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_PASSB  = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_PASSA  = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_REGA   = 2'b10;

    typedef struct packed {
        logic mem_ld;
        logic mem_st;
        logic rtype;
        logic cbz;
        logic b;
        logic bl;
        logic br;
        logic illegal;
    } op_class_t;

endpackage
`default_nettype wire

// File: rtl/legv8_multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : legv8_multicycle_control_if
// Brief    : Control <-> datapath bundle; master is the sequencer side
// Revision : 1.0
// ============================================================================
interface legv8_multicycle_control_if;
    logic [10:0] iOp;
    logic        iZero;
    logic        iMemReady;
    logic        oPCWrite;
    logic        oPCWriteCond;
    logic        oIorD;
    logic        oMemRead;
    logic        oMemWrite;
    logic        oIRWrite;
    logic        oReg2Loc;
    logic        oRegWrite;
    logic        oMemtoReg;
    logic        oRegDst;
    logic        oALUSrcA;
    logic [1:0]  oALUSrcB;
    logic [1:0]  oOpALU;
    logic [1:0]  oPCSource;
    logic [3:0]  oState;
    logic        oRetire;
    logic        oIllegal;

    modport master (
        input  iOp, iZero, iMemReady,
        output oPCWrite, oPCWriteCond, oIorD, oMemRead, oMemWrite, oIRWrite,
               oReg2Loc, oRegWrite, oMemtoReg, oRegDst, oALUSrcA, oALUSrcB,
               oOpALU, oPCSource, oState, oRetire, oIllegal
    );

    modport slave (
        output iOp, iZero, iMemReady,
        input  oPCWrite, oPCWriteCond, oIorD, oMemRead, oMemWrite, oIRWrite,
               oReg2Loc, oRegWrite, oMemtoReg, oRegDst, oALUSrcA, oALUSrcB,
               oOpALU, oPCSource, oState, oRetire, oIllegal
    );
endinterface
`default_nettype wire

// File: rtl/legv8_op_class.sv
`default_nettype none
// ============================================================================
// Module   : legv8_op_class
// Brief    : Classifies IR[31:21] into a one-hot instruction class
// Revision : 1.0
// ============================================================================
module legv8_op_class
    import legv8_pkg::*;
(
    input  logic [10:0] op_i,
    output op_class_t   class_o
);
    always_comb begin
        class_o = '0;
        if (op_i == OP_LDUR)                          class_o.mem_ld  = 1'b1;
        else if (op_i == OP_STUR)                     class_o.mem_st  = 1'b1;
        else if (op_i == OP_ADD || op_i == OP_SUB ||
                 op_i == OP_AND || op_i == OP_ORR)    class_o.rtype   = 1'b1;
        else if (op_i == OP_BR)                       class_o.br      = 1'b1;
        else if (op_i[10:3] == OP_CBZ_HI)             class_o.cbz     = 1'b1;
        else if (op_i[10:5] == OP_B_HI)               class_o.b       = 1'b1;
        else if (op_i[10:5] == OP_BL_HI)              class_o.bl      = 1'b1;
        else                                          class_o.illegal = 1'b1;
    end
endmodule
`default_nettype wire

// File: rtl/legv8_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : legv8_multicycle_control
// Brief    : Multicycle LEGv8 sequencer driving datapath muxes and strobes
// Revision : 1.0
// ============================================================================
module legv8_multicycle_control
    import legv8_pkg::*;
(
    input  wire logic                    iCLK,
    input  wire logic                    iRST_n,
    legv8_multicycle_control_if.master   bus
);
    state_e    state_q, state_d;
    logic      run_q;
    op_class_t cls;

    legv8_op_class u_op_class (
        .op_i    (bus.iOp),
        .class_o (cls)
    );

    // run_q holds off the first FETCH until the edge after reset release.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            state_q <= run_q ? state_d : S_FETCH;
        end
    end

    assign bus.oState = state_q;

    always_comb begin
        state_d          = state_q;
        bus.oPCWrite     = 1'b0;
        bus.oPCWriteCond = 1'b0;
        bus.oIorD        = 1'b0;
        bus.oMemRead     = 1'b0;
        bus.oMemWrite    = 1'b0;
        bus.oIRWrite     = 1'b0;
        bus.oReg2Loc     = 1'b0;
        bus.oRegWrite    = 1'b0;
        bus.oMemtoReg    = 1'b0;
        bus.oRegDst      = 1'b0;
        bus.oALUSrcA     = 1'b0;
        bus.oALUSrcB     = SRCB_REG;
        bus.oOpALU       = ALU_ADD;
        bus.oPCSource    = PCS_ALU;
        bus.oRetire      = 1'b0;
        bus.oIllegal     = 1'b0;
        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    bus.oMemRead = 1'b1;
                    bus.oALUSrcB = SRCB_FOUR;
                    if (bus.iMemReady) begin
                        bus.oIRWrite = 1'b1;
                        bus.oPCWrite = 1'b1;
                        state_d      = S_DECODE;
                    end
                end
                S_DECODE: begin
                    bus.oALUSrcB = SRCB_BROFF;
                    bus.oReg2Loc = cls.mem_st | cls.cbz;
                    if (cls.mem_ld | cls.mem_st) state_d = S_MEMADDR;
                    else if (cls.rtype)          state_d = S_EXEC_R;
                    else if (cls.cbz)            state_d = S_CBZ;
                    else if (cls.b)              state_d = S_B;
                    else if (cls.bl)             state_d = S_BL;
                    else if (cls.br)             state_d = S_BR;
                    else                         state_d = S_HALT;
                end
                S_MEMADDR: begin
                    bus.oALUSrcA = 1'b1;
                    bus.oALUSrcB = SRCB_DIMM;
                    state_d      = cls.mem_st ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    bus.oIorD    = 1'b1;
                    bus.oMemRead = 1'b1;
                    if (bus.iMemReady) state_d = S_MEMWB;
                end
                S_MEMWB: begin
                    bus.oRegWrite = 1'b1;
                    bus.oMemtoReg = 1'b1;
                    bus.oRetire   = 1'b1;
                    state_d       = S_FETCH;
                end
                S_MEMWRITE: begin
                    bus.oIorD     = 1'b1;
                    bus.oMemWrite = 1'b1;
                    bus.oReg2Loc  = 1'b1;
                    if (bus.iMemReady) begin
                        bus.oRetire = 1'b1;
                        state_d     = S_FETCH;
                    end
                end
                S_EXEC_R: begin
                    bus.oALUSrcA = 1'b1;
                    bus.oOpALU   = ALU_FUNCT;
                    state_d      = S_RWB;
                end
                S_RWB: begin
                    bus.oRegWrite = 1'b1;
                    bus.oRetire   = 1'b1;
                    state_d       = S_FETCH;
                end
                S_CBZ: begin
                    bus.oReg2Loc     = 1'b1;
                    bus.oOpALU       = ALU_PASSB;
                    bus.oPCWriteCond = 1'b1;
                    bus.oPCSource    = PCS_ALUOUT;
                    bus.oRetire      = 1'b1;
                    state_d          = S_FETCH;
                end
                S_B: begin
                    bus.oPCWrite  = 1'b1;
                    bus.oPCSource = PCS_ALUOUT;
                    bus.oRetire   = 1'b1;
                    state_d       = S_FETCH;
                end
                // PC-select on SrcA with pass-A writes the already-incremented PC to X30.
                S_BL: begin
                    bus.oPCWrite  = 1'b1;
                    bus.oPCSource = PCS_ALUOUT;
                    bus.oRegWrite = 1'b1;
                    bus.oRegDst   = 1'b1;
                    bus.oOpALU    = ALU_PASSA;
                    bus.oRetire   = 1'b1;
                    state_d       = S_FETCH;
                end
                S_BR: begin
                    bus.oPCWrite  = 1'b1;
                    bus.oPCSource = PCS_REGA;
                    bus.oRetire   = 1'b1;
                    state_d       = S_FETCH;
                end
                default: begin
                    bus.oIllegal = 1'b1;
                    state_d      = S_HALT;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: doc/legv8_multicycle_control.md
# legv8_multicycle_control

Multicycle sequencer for the LEGv8 core. It replaces the single-cycle decode-only control with a Moore/Mealy FSM. The FSM steps each instruction through fetch, decode, execute, memory and writeback over 3–5 cycles, sharing one ALU and one unified memory port. It sits between the instruction register and the datapath muxes/write enables, and stalls on a memory ready handshake.

## Interface
Parameters:
- none; opcodes and state codes come from the shared package.

Ports:
- iCLK  in  1  core clock; all state updates on rising edge
- iRST_n  in  1  asynchronous, active-low reset
- iOp  in  11  IR[31:21] opcode field, valid from DECODE onward
- iZero  in  1  ALU zero flag (current cycle)
- iMemReady  in  1  memory port has completed the current read/write this cycle
- oPCWrite, oPCWriteCond  out  1 each  unconditional / zero-qualified PC load
- oIorD  out  1  memory address: 0 = PC, 1 = ALUOut
- oMemRead, oMemWrite, oIRWrite  out  1 each  memory strobes, IR load
- oReg2Loc  out  1  register read port 2: 0 = Rm, 1 = Rt
- oRegWrite, oMemtoReg  out  1 each  register write enable; write data 1 = MDR, 0 = ALUOut/ALU
- oRegDst  out  1  write register: 0 = Rd, 1 = X30
- oALUSrcA  out  1  0 = PC, 1 = reg A
- oALUSrcB  out  2  00 = reg B, 01 = const 4, 10 = sign-extended D imm, 11 = branch offset<<2
- oOpALU  out  2  00 add, 01 pass B, 10 funct-decoded, 11 pass A
- oPCSource  out  2  00 = ALU, 01 = ALUOut, 10 = reg A
- oState  out  4  current state code
- oRetire  out  1  one-cycle pulse on an instruction's final cycle
- oIllegal  out  1  high while in HALT

## Operation
- States and their non-zero outputs (all unlisted outputs are 0):
  - FETCH(0): IorD=0, MemRead=1, SrcA=0, SrcB=01, OpALU=00. If iMemReady: IRWrite=1, PCWrite=1, PCSource=00, next DECODE; else hold.
  - DECODE(1): SrcA=0, SrcB=11, OpALU=00 (target into ALUOut). Reg2Loc=1 if STUR/CBZ. Next state by opcode:
    - LDUR/STUR → MEMADDR
    - ADD/SUB/AND/ORR → EXEC_R
    - CBZ → CBZ
    - B → B
    - BL → BL
    - BR → BR
    - anything else → HALT
  - MEMADDR(2): SrcA=1, SrcB=10, OpALU=00. Next MEMREAD (LDUR) or MEMWRITE (STUR).
  - MEMREAD(3): IorD=1, MemRead=1. On iMemReady → MEMWB; else hold.
  - MEMWB(4): RegWrite=1, MemtoReg=1, Retire=1 → FETCH.
  - MEMWRITE(5): IorD=1, MemWrite=1, Reg2Loc=1. On iMemReady: Retire=1 → FETCH; else hold.
  - EXEC_R(6): SrcA=1, SrcB=00, OpALU=10 → RWB.
  - RWB(7): RegWrite=1, MemtoReg=0, Retire=1 → FETCH.
  - CBZ(8): Reg2Loc=1, SrcB=00, OpALU=01, PCWriteCond=1, PCSource=01, Retire=1 → FETCH.
  - B(9): PCWrite=1, PCSource=01, Retire=1 → FETCH.
  - BL(10): PCWrite=1, PCSource=01, RegWrite=1, RegDst=1, SrcA=0, OpALU=11, Retire=1 → FETCH. The link value is the already-incremented PC, captured at the same edge the PC loads.
  - BR(11): PCWrite=1, PCSource=10, Retire=1 → FETCH.
  - HALT(15): Illegal=1; absorbing until reset.
- Opcode matching:
  - full 11 bits for LDUR 7C2h, STUR 7C0h, ADD 458h, SUB 658h, AND 450h, ORR 550h, BR 6B0h
  - iOp[10:3]=B4h for CBZ
  - iOp[10:5]=05h for B, 25h for BL
- oPCWriteCond is qualified by iZero in the datapath, not here.
- Outputs are combinational from state, iOp and iMemReady; no output registers.

## Timing
- Reset: while iRST_n=0, state=FETCH and every output is forced 0, including MemRead. Reset mid-instruction abandons it with no partial writes. After release, the first FETCH cycle begins on the next edge.
- Cycles per instruction with iMemReady always 1: LDUR 5, STUR 4, R-type 4, CBZ/B/BL/BR 3.
- Each cycle with iMemReady=0 in FETCH/MEMREAD/MEMWRITE adds one cycle. During that stall, strobes and address select stay constant, and IRWrite, PCWrite and Retire stay 0.
- Memory strobes must stay asserted until the ready cycle, inclusive. iMemReady outside memory states is ignored.
- oRetire: exactly one pulse per legal instruction; never pulses in HALT.

## Structure
- Package legv8_pkg:
  - opcode constants
  - 4-bit state codes
  - ALUSrcB, OpALU and PCSource encodings
- Sub-module legv8_op_class: combinational iOp → one-hot class {mem_ld, mem_st, rtype, cbz, b, bl, br, illegal}, used in DECODE/MEMADDR.

## Test plan
- Reset held low 3 cycles, then released with iMemReady=1, iOp=458h → states 0,1,6,7,0; one Retire in state 7; all outputs 0 during reset.
- LDUR (7C2h), iMemReady low 2 cycles in MEMREAD → 7 cycles total; MemRead/IorD=1 steady over 3 cycles; RegWrite+MemtoReg only in MEMWB.
- STUR (7C0h) → Reg2Loc=1 in DECODE/MEMWRITE; MemWrite 1 cycle; RegWrite never 1.
- CBZ (B4h<<3 | 3), then BL (25h<<5) → CBZ: PCWriteCond=1, PCSource=01 in state 8. BL: RegDst=1, RegWrite=1, PCWrite=1 in one cycle.
- iOp=000h in DECODE → HALT; oIllegal=1, oState=15 held for 20 cycles, no strobes. Reset recovers to FETCH.
- iRST_n pulsed low during MEMWRITE with ready=0 → MemWrite drops asynchronously, state=0, no Retire.
